// File: rtl/spi_regfile_pkg.sv
// -----------------------------------------------------------------------------
// spi_regfile_pkg
// Shared definitions for the SPI register-file peripheral:
//   - state_e        : frame FSM states
//   - frame_w()      : total frame length (R/W bit + address + data)
//   - sample_on_rise(): which SCLK edge samples COPI for a given CPOL/CPHA
// -----------------------------------------------------------------------------
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    END   = 3'd4
  } state_e;

  // Frame is one R/W bit, then the address field, then the data field.
  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Rising edge samples when CPOL and CPHA agree (modes 0 and 3),
  // falling edge samples otherwise (modes 1 and 2).
  function automatic bit sample_on_rise(input bit cpol, input bit cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_regfile_rw_if.sv
// -----------------------------------------------------------------------------
// spi_regfile_rw_if
// SPI pin bundle between a bus master and the register-file peripheral.
//   sclk, ncs, copi : driven by the master, asynchronous to the peripheral clk
//   cipo            : read data from the peripheral, MSB first
//   cipo_oe         : high while the peripheral drives read data
// Modports: master (drives the clock/select/data-out pins), slave (peripheral).
// -----------------------------------------------------------------------------
interface spi_regfile_rw_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (
    output sclk,
    output ncs,
    output copi,
    input  cipo,
    input  cipo_oe
  );

  modport slave (
    input  sclk,
    input  ncs,
    input  copi,
    output cipo,
    output cipo_oe
  );
endinterface

// File: rtl/spi_regfile_rw_edge_sync.sv
// -----------------------------------------------------------------------------
// spi_edge_sync
// Brings the asynchronous SPI pins into the clk domain and produces one-cycle
// edge pulses for sclk and ncs.
//   clk, rst              : system clock, synchronous active-high reset
//   sclk, ncs, copi       : raw SPI pins
//   sclk_rise / sclk_fall : one-cycle pulses on synchronised SCLK edges
//   ncs_rise  / ncs_fall  : one-cycle pulses on synchronised nCS edges
//   copi_s                : COPI from the stage aligned with the sclk edge detect
// Pulses appear SYNC_STAGES clk after the pin edge and are acted on one clk
// later by the consumer.
// -----------------------------------------------------------------------------
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ncs,
  input  logic copi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ncs_rise,
  output logic ncs_fall,
  output logic copi_s
);

  localparam int LAST = SYNC_STAGES - 1;

  logic [LAST:0]        sclk_q;
  logic [LAST:0]        ncs_q;
  logic [LAST:0]        copi_q;
  logic                 sclk_prev_q;
  logic                 ncs_prev_q;
  logic [SYNC_STAGES:0] live_q;
  logic                 live;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= {SYNC_STAGES{CPOL}};
      ncs_q       <= '1;
      copi_q      <= '0;
      sclk_prev_q <= CPOL;
      ncs_prev_q  <= 1'b1;
      live_q      <= '0;
    end else begin
      sclk_q      <= {sclk_q[LAST-1:0], sclk};
      ncs_q       <= {ncs_q[LAST-1:0], ncs};
      copi_q      <= {copi_q[LAST-1:0], copi};
      sclk_prev_q <= sclk_q[LAST];
      ncs_prev_q  <= ncs_q[LAST];
      live_q      <= {live_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // After reset the chains hold their reset values rather than the real pin
  // levels. Until the real levels have propagated through the chain and the
  // previous-value flop, any difference is an artefact of reset (e.g. nCS
  // still low mid-frame) and must not be reported as an edge.
  assign live = live_q[SYNC_STAGES];

  assign sclk_rise = live &  sclk_q[LAST] & ~sclk_prev_q;
  assign sclk_fall = live & ~sclk_q[LAST] &  sclk_prev_q;
  assign ncs_rise  = live &  ncs_q[LAST]  & ~ncs_prev_q;
  assign ncs_fall  = live & ~ncs_q[LAST]  &  ncs_prev_q;
  assign copi_s    = copi_q[LAST];

endmodule

// File: rtl/spi_regfile_rw.sv
// -----------------------------------------------------------------------------
// spi_regfile_rw
// SPI slave exposing NUM_REGS registers of DATA_W bits as a flat parallel bus.
// Frame (MSB first): R/W bit (1 = write), ADDR_W address bits, DATA_W data bits.
// Writes are committed atomically when nCS rises after a complete frame; reads
// shift the addressed register out on cipo during the data phase.
//   clk, rst  : system clock, synchronous active-high reset
//   spi       : SPI pins (slave modport)
//   regs      : register r at [r*DATA_W +: DATA_W]
//   wr_strobe : one-cycle pulse when a write commits
//   wr_addr   : address of the last committed write
//   err       : one-cycle pulse when a frame is discarded
// -----------------------------------------------------------------------------
module spi_regfile_rw
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_regfile_rw_if.slave            spi,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       err
);

  localparam int               FRAME_W     = frame_w(ADDR_W, DATA_W);
  localparam int               CNT_W       = $clog2(FRAME_W + 1);
  localparam bit               SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam logic [ADDR_W:0]  NUM_REGS_X  = (ADDR_W + 1)'(NUM_REGS);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_ADDR  = ADDR;
  localparam logic [2:0] S_WDATA = WDATA;
  localparam logic [2:0] S_RDATA = RDATA;
  localparam logic [2:0] S_END   = END;

  // ---------------------------------------------------------------------------
  // Pin synchronisation and edge detection
  // ---------------------------------------------------------------------------
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .CPOL       (CPOL)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sclk     (spi.sclk),
    .ncs      (spi.ncs),
    .copi     (spi.copi),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .ncs_rise (ncs_rise),
    .ncs_fall (ncs_fall),
    .copi_s   (copi_s)
  );

  logic sample_edge, shift_edge;
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [FRAME_W-1:0] rx_q;
  logic [DATA_W-1:0]  tx_q;
  logic               cipo_q;
  logic               cipo_oe_q;
  logic               overrun_q;
  logic               wr_strobe_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic               err_q;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Frame decode
  // ---------------------------------------------------------------------------
  // rx_shift is the receive register as it will be after the current sample;
  // on the last header sample it already holds R/W and the full address,
  // which is what the read path needs to load tx in the same cycle.
  logic [FRAME_W-1:0] rx_shift;
  logic               hdr_rw;
  logic [ADDR_W-1:0]  hdr_addr;
  logic               frm_rw;
  logic [ADDR_W-1:0]  frm_addr;
  logic [DATA_W-1:0]  frm_data;
  logic               frm_addr_ok;
  logic [DATA_W-1:0]  rd_word;
  logic               commit;
  logic               frame_err;

  assign rx_shift    = {rx_q[FRAME_W-2:0], copi_s};
  assign hdr_rw      = rx_shift[ADDR_W];
  assign hdr_addr    = rx_shift[ADDR_W-1:0];
  assign frm_rw      = rx_q[FRAME_W-1];
  assign frm_addr    = rx_q[FRAME_W-2 -: ADDR_W];
  assign frm_data    = rx_q[DATA_W-1:0];
  assign frm_addr_ok = {1'b0, frm_addr} < NUM_REGS_X;

  // Out-of-range addresses match no register and read back as zero.
  always_comb begin
    rd_word = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (hdr_addr == ADDR_W'(r)) begin
        rd_word = regs_q[r];
      end
    end
  end

  // nCS fall outranks nCS rise; both are evaluated on the synchronised pulses.
  assign commit = ncs_rise && !ncs_fall && (state_q == S_END) &&
                  frm_rw && !overrun_q && frm_addr_ok;

  always_comb begin
    frame_err = 1'b0;
    if (ncs_rise && !ncs_fall) begin
      case (state_q)
        S_ADDR, S_WDATA, S_RDATA: frame_err = 1'b1;
        S_END:                    frame_err = overrun_q || (frm_rw && !frm_addr_ok);
        default:                  frame_err = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM, shift registers and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      overrun_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_strobe_q <= commit;
      err_q       <= frame_err;
      if (commit) begin
        wr_addr_q <= frm_addr;
      end

      if (ncs_fall) begin
        state_q   <= S_ADDR;
        cnt_q     <= '0;
        rx_q      <= '0;
        tx_q      <= '0;
        cipo_q    <= 1'b0;
        cipo_oe_q <= 1'b0;
        overrun_q <= 1'b0;
      end else if (ncs_rise) begin
        state_q   <= S_IDLE;
        cipo_q    <= 1'b0;
        cipo_oe_q <= 1'b0;
      end else if (sample_edge) begin
        case (state_q)
          S_ADDR: begin
            rx_q  <= rx_shift;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ADDR_W)) begin
              if (hdr_rw) begin
                state_q <= S_WDATA;
              end else begin
                state_q   <= S_RDATA;
                tx_q      <= rd_word;
                cipo_oe_q <= 1'b1;
              end
            end
          end
          S_WDATA, S_RDATA: begin
            rx_q  <= rx_shift;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_W - 1)) begin
              state_q <= S_END;
            end
          end
          S_END: begin
            // Extra clocks after a full frame poison it until nCS rises.
            overrun_q <= 1'b1;
          end
          default: begin
          end
        endcase
      end else if (shift_edge && (state_q == S_RDATA)) begin
        cipo_q <= tx_q[DATA_W-1];
        tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: updated only by a committed write
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (commit) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (frm_addr == ADDR_W'(r)) begin
          regs_q[r] <= frm_data;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign regs[gi*DATA_W +: DATA_W] = regs_q[gi];
  end

  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = cipo_oe_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign err         = err_q;

endmodule

// File: tb/tb_spi_regfile_rw.sv
// -----------------------------------------------------------------------------
// tb_spi_regfile_rw
// Four peripherals, one per SPI mode (index = CPOL*2 + CPHA), share clk/rst.
// A task-level SPI master drives one mode at a time; a reference register
// image per mode is updated only from frame-level rules, and a compare
// process checks every idle cycle against it.
// -----------------------------------------------------------------------------
module tb_spi_regfile_rw;

  localparam int HALF = 8;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sclk_m   [4];
  logic        ncs_m    [4];
  logic        copi_m   [4];
  logic        cipo_w   [4];
  logic        oe_w     [4];
  logic [63:0] regs_w   [4];
  logic        strobe_w [4];
  logic        err_w    [4];
  logic [6:0]  wra_w    [4];

  // reference state
  logic [63:0] model_regs [4];
  logic [6:0]  model_wra  [4];
  logic [6:0]  cur_addr   [4];
  bit          quiet      [4];
  int          strobe_cnt [4];
  int          err_cnt    [4];

  int total = 0;
  int bad   = 0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mode
    spi_regfile_rw_if ifc ();
    assign ifc.sclk     = sclk_m[gi];
    assign ifc.ncs      = ncs_m[gi];
    assign ifc.copi     = copi_m[gi];
    assign cipo_w[gi]   = ifc.cipo;
    assign oe_w[gi]     = ifc.cipo_oe;

    spi_regfile_rw #(
      .NUM_REGS   (8),
      .DATA_W     (8),
      .ADDR_W     (7),
      .CPOL       (bit'(gi / 2)),
      .CPHA       (bit'(gi % 2)),
      .SYNC_STAGES(2)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .spi      (ifc),
      .regs     (regs_w[gi]),
      .wr_strobe(strobe_w[gi]),
      .wr_addr  (wra_w[gi]),
      .err      (err_w[gi])
    );
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare: count pulses, and when a mode is between frames its
  // outputs must equal the reference image with every pin output at rest.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int m = 0; m < 4; m++) begin
        if (strobe_w[m] === 1'b1) begin
          strobe_cnt[m]++;
          check($sformatf("m%0d_wr_addr_on_strobe", m), 128'(wra_w[m]), 128'(cur_addr[m]));
        end
        if (err_w[m] === 1'b1) err_cnt[m]++;
        if (quiet[m]) begin
          check($sformatf("m%0d_idle_outputs", m),
                128'({regs_w[m], wra_w[m], oe_w[m], cipo_w[m], strobe_w[m], err_w[m]}),
                128'({model_regs[m], model_wra[m], 4'b0000}));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int m);
    for (int k = 0; k < 4; k++) quiet[k] = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      model_regs[k] = '0;
      model_wra[k]  = '0;
    end
    tick(1);
    for (int k = 0; k < 4; k++) if (k != m) quiet[k] = 1'b1;
  endtask

  // Bit-level SPI master. Captures cipo and cipo_oe at each sample edge.
  task automatic spi_xfer(input int m, input logic [31:0] frame, input int nbits,
                          input int rst_at, output logic [31:0] miso, output logic [31:0] oev);
    logic pol;
    logic pha;
    pol  = ((m >> 1) & 1) != 0;
    pha  = (m & 1) != 0;
    miso = '0;
    oev  = '0;
    ncs_m[m] = 1'b0;
    tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) do_reset(m);
      if (!pha) begin
        copi_m[m] = frame[nbits-1-i];
        tick(HALF);
        sclk_m[m] = ~pol;
        miso = {miso[30:0], cipo_w[m]};
        oev  = {oev[30:0], oe_w[m]};
        tick(HALF);
        sclk_m[m] = pol;
      end else begin
        sclk_m[m] = ~pol;
        copi_m[m] = frame[nbits-1-i];
        tick(HALF);
        sclk_m[m] = pol;
        miso = {miso[30:0], cipo_w[m]};
        oev  = {oev[30:0], oe_w[m]};
        tick(HALF);
      end
    end
    tick(HALF);
    ncs_m[m] = 1'b1;
    tick(HALF);
  endtask

  // Frame-level expectation: complete write to a legal address commits,
  // complete read returns the register (or 0), anything else flags err.
  task automatic run_frame(input int m, input logic [31:0] frame, input int nbits,
                           input int rst_at, output logic [7:0] rd_byte);
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [7:0]  exp_rd;
    logic [31:0] miso;
    logic [31:0] oev;
    int          a, exp_wr, exp_err, s0, e0;
    rw      = frame[15];
    addr    = frame[14:8];
    data    = frame[7:0];
    a       = int'(addr);
    exp_wr  = 0;
    exp_err = 0;
    if (rst_at >= 0) begin
      exp_wr = 0;
    end else if (nbits != 16) begin
      exp_err = 1;
    end else if (rw) begin
      if (a < 8) exp_wr = 1;
      else exp_err = 1;
    end
    exp_rd = (a < 8) ? model_regs[m][a*8 +: 8] : 8'h00;

    cur_addr[m] = addr;
    quiet[m]    = 1'b0;
    s0 = strobe_cnt[m];
    e0 = err_cnt[m];
    spi_xfer(m, frame, nbits, rst_at, miso, oev);
    tick(20);

    check($sformatf("m%0d_strobe_count", m), 128'(strobe_cnt[m] - s0), 128'(exp_wr));
    check($sformatf("m%0d_err_count", m), 128'(err_cnt[m] - e0), 128'(exp_err));
    if (nbits == 16 && rst_at < 0) begin
      if (!rw) begin
        check($sformatf("m%0d_read_data", m), 128'(miso[15:0]), 128'({8'h00, exp_rd}));
        check($sformatf("m%0d_oe_window", m), 128'(oev[15:0]), 128'(16'h00FF));
      end else begin
        check($sformatf("m%0d_oe_window", m), 128'(oev[15:0]), 128'(16'h0000));
      end
    end
    rd_byte = miso[7:0];
    if (exp_wr != 0) begin
      model_regs[m][a*8 +: 8] = data;
      model_wra[m] = addr;
    end
    quiet[m] = 1'b1;
    $display("xfer mode=%0d frame=%0h bits=%0d rst_at=%0d strobe=%0d err=%0d rd=%02h",
             m, frame, nbits, rst_at, strobe_cnt[m] - s0, err_cnt[m] - e0, miso[7:0]);
  endtask

  logic [7:0] rb;

  initial begin
    rst = 1'b1;
    for (int m = 0; m < 4; m++) begin
      sclk_m[m]     = ((m >> 1) & 1) != 0;
      ncs_m[m]      = 1'b1;
      copi_m[m]     = 1'b0;
      quiet[m]      = 1'b0;
      strobe_cnt[m] = 0;
      err_cnt[m]    = 0;
      model_regs[m] = '0;
      model_wra[m]  = '0;
      cur_addr[m]   = '0;
    end
    tick(5);
    rst = 1'b0;
    tick(10);

    // reset state
    check("reset_regs", 128'(regs_w[0]), 128'(64'h0));
    check("reset_cipo_oe", 128'({cipo_w[0], oe_w[0]}), 128'(2'b00));
    check("reset_pulses", 128'({strobe_w[0], err_w[0]}), 128'(2'b00));
    check("reset_wr_addr", 128'(wra_w[0]), 128'(7'd0));
    for (int m = 0; m < 4; m++) quiet[m] = 1'b1;

    // mode 0 write addr 0
    run_frame(0, 32'h80A5, 16, -1, rb);
    check("t1_reg0", 128'(regs_w[0][7:0]), 128'(8'hA5));
    check("t1_wr_addr", 128'(wra_w[0]), 128'(7'd0));

    // mode 0 write addr 3 then read it back
    run_frame(0, 32'h833C, 16, -1, rb);
    run_frame(0, 32'h0300, 16, -1, rb);
    check("t2_read_literal", 128'(rb), 128'(8'h3C));
    check("t2_reg3", 128'(regs_w[0][31:24]), 128'(8'h3C));

    // modes 1..3: write addr 4 then read back
    for (int m = 1; m < 4; m++) begin
      run_frame(m, 32'h8481, 16, -1, rb);
      run_frame(m, 32'h0400, 16, -1, rb);
      check($sformatf("t3_m%0d_read_literal", m), 128'(rb), 128'(8'h81));
      check($sformatf("t3_m%0d_reg4", m), 128'(regs_w[m][39:32]), 128'(8'h81));
    end

    // short (10-bit) and long (17-bit) frames
    run_frame(0, 32'h0000_0211, 10, -1, rb);
    run_frame(0, 32'h0001_08AB, 17, -1, rb);
    check("t4_regs_kept", 128'(regs_w[0]), 128'(64'h0000_0000_3C00_00A5));

    // out-of-range address write and read
    run_frame(0, 32'h9077, 16, -1, rb);
    run_frame(0, 32'h1000, 16, -1, rb);
    check("t5_read_oob", 128'(rb), 128'(8'h00));

    // reset at bit 6 of a write, then a normal write
    run_frame(0, 32'h8199, 16, 6, rb);
    check("t6_after_abort", 128'(regs_w[0]), 128'(64'h0));
    run_frame(0, 32'h8266, 16, -1, rb);
    check("t6_commit", 128'(regs_w[0]), 128'(64'h0000_0000_0066_0000));
    check("t6_wr_addr", 128'(wra_w[0]), 128'(7'd2));

    tick(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
